// File: rtl/fir_output_stage.sv
// FIR output stage: re-aligns the sample strobe, drops warm-up sums, quantises to OUT_W and buffers in a FIFO.
// Build option FIR_OUT_ROUND_EN: round-half-up before the shift; when undefined the accumulator is truncated.
module fir_output_stage #(
  parameter int ACC_W  = 12,
  parameter int OUT_W  = 8,
  parameter int SHIFT  = 4,
  parameter int LAT    = 9,
  parameter int WARMUP = 3,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [ACC_W-1:0]       acc_in,
  output logic [OUT_W-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   sat_flag,
  output logic                   drop_flag
);
  localparam int AW  = $clog2(DEPTH);
  localparam int WW  = $clog2(WARMUP + 2);
  localparam int QW  = ACC_W + 1;
  localparam logic [WW-1:0] WARM_LAST = WW'(WARMUP);
  localparam logic [QW-1:0] OUT_MAX   = QW'((1 << OUT_W) - 1);
`ifdef FIR_OUT_ROUND_EN
  localparam logic [QW-1:0] HALF      = QW'(1 << (SHIFT - 1));
`endif

  // Strobe delay line: tap LAT-1 is high at the edge where acc_in carries that sample's sum.
  logic valid_dly_reg [LAT];
  genvar gi;
  generate
    for (gi = 0; gi < LAT; gi++) begin : g_dly
      if (gi == 0) begin : g_head
        always_ff @(posedge clk) begin
          if (rst) valid_dly_reg[gi] <= 1'b0;
          else     valid_dly_reg[gi] <= in_valid;
        end
      end else begin : g_tap
        always_ff @(posedge clk) begin
          if (rst) valid_dly_reg[gi] <= 1'b0;
          else     valid_dly_reg[gi] <= valid_dly_reg[gi-1];
        end
      end
    end
  endgenerate

  logic aligned;
  assign aligned = valid_dly_reg[LAT-1];

  logic [QW-1:0]    sum_w;
  logic [QW-1:0]    scaled_w;
  logic [OUT_W-1:0] q_next;
  logic             q_sat_next;

  always_comb begin
`ifdef FIR_OUT_ROUND_EN
    sum_w = {1'b0, acc_in} + HALF;
`else
    sum_w = {1'b0, acc_in};
`endif
    scaled_w = sum_w >> SHIFT;
    if (scaled_w > OUT_MAX) begin
      q_next     = '1;
      q_sat_next = 1'b1;
    end else begin
      q_next     = scaled_w[OUT_W-1:0];
      q_sat_next = 1'b0;
    end
  end

  logic [WW-1:0]    warm_cnt_reg;
  logic             q_valid_reg;
  logic [OUT_W-1:0] q_data_reg;
  logic             q_sat_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      warm_cnt_reg <= '0;
      q_valid_reg  <= 1'b0;
      q_data_reg   <= '0;
      q_sat_reg    <= 1'b0;
    end else begin
      q_valid_reg <= 1'b0;
      if (aligned) begin
        if (warm_cnt_reg < WARM_LAST) begin
          warm_cnt_reg <= warm_cnt_reg + 1'b1;
        end else begin
          q_valid_reg <= 1'b1;
          q_data_reg  <= q_next;
          q_sat_reg   <= q_sat_next;
        end
      end
    end
  end

  // Circular buffer; the extra pointer bit separates full from empty.
  logic [OUT_W-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             full;
  logic             empty;
  logic             pop;
  logic             wr_en;
  logic             sat_flag_reg;
  logic             drop_flag_reg;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg == {~rd_ptr_reg[AW], rd_ptr_reg[AW-1:0]});
  assign pop   = !empty && out_ready;
  assign wr_en = q_valid_reg && (!full || pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg[AW-1:0]] <= q_data_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      sat_flag_reg  <= 1'b0;
      drop_flag_reg <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)   rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (wr_en && q_sat_reg)            sat_flag_reg  <= 1'b1;
      if (q_valid_reg && full && !pop)   drop_flag_reg <= 1'b1;
    end
  end

  assign out_valid = !empty;
  assign out_data  = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];
  assign level     = wr_ptr_reg - rd_ptr_reg;
  assign sat_flag  = sat_flag_reg;
  assign drop_flag = drop_flag_reg;

endmodule

// File: doc/fir_output_stage.md
# fir_output_stage

Output stage of the modulator's FIR datapath, directly downstream of the last DSP slice in the systolic chain. Re-aligns a sample-valid strobe to the chain's accumulator output, discards warm-up partial sums, then rounds, scales and saturates the 12-bit accumulator to the DAC/mapper word width. Buffers results in a small FIFO with a valid/ready handshake to the consumer.

## Interface
Parameters:
- ACC_W, 12, accumulator width from the slice chain
- OUT_W, 8, output sample width
- SHIFT, 4, right-shift (scale) applied to the accumulator, must be ≥ 1
- LAT, 9, edges from in_valid sampled to the matching result on acc_in
- WARMUP, 3, number of aligned results discarded after reset
- DEPTH, 4, FIFO depth, power of two

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  high in the cycle a new x_n enters the first slice
- acc_in  in  ACC_W  acc_out of the last slice, unsigned
- out_data  out  OUT_W  FIFO head sample
- out_valid  out  1  FIFO not empty
- out_ready  in  1  consumer accepts out_data this cycle
- level  out  log2(DEPTH)+1  current FIFO occupancy
- sat_flag  out  1  sticky: any accepted sample saturated
- drop_flag  out  1  sticky: any sample lost to a full FIFO

## Operation
- Valid alignment: LAT-bit shift register of in_valid; tap LAT-1 marks the edge at which acc_in holds that sample's sum.
- Warm-up: counter 0..WARMUP; while below WARMUP, each aligned valid increments it and the result is discarded (no push, no flags). Saturates at WARMUP.
- Quantise (unsigned, ACC_W+1 bits internally): r = (acc_in + 2^(SHIFT-1)) >> SHIFT; out = min(r, 2^OUT_W − 1). Clamping sets sat_flag.
- Quantised value registered into q_data/q_valid stage, then pushed to FIFO.
- FIFO: circular buffer, read/write pointers one bit wider than index. Pop = out_valid && out_ready. Push = q_valid.
- Full and push without pop: sample dropped, drop_flag set, contents unchanged. Full with push and pop same cycle: both occur, level unchanged.
- Empty and push: pop not possible that cycle (out_valid low); data visible next cycle.
- out_data is the head entry, stable while out_valid && !out_ready.
- Sticky flags clear only on rst.

## Timing
- Reset (rst high at an edge): out_valid=0, out_data=0, level=0, sat_flag=0, drop_flag=0, delay line, q_valid and warm-up counter cleared. Mid-operation reset discards all in-flight and buffered samples; in_valid pulses before reset never produce output.
- in_valid sampled at edge k → acc_in sampled and quantised at edge k+LAT → FIFO write at edge k+LAT+1 → out_valid high after edge k+LAT+1 (if FIFO was empty).
- Throughput: one sample per clock sustained while out_ready held high.
- level updates at the same edge as the push/pop it reflects.

## Configuration
- FIR_OUT_ROUND_EN defined: round-half-up as above (add 2^(SHIFT-1) before shift).
- Undefined: pure truncation, r = acc_in >> SHIFT; saturation logic retained but unreachable for default widths (4095>>4 = 255).

## Test plan
- Reset then in_valid every cycle, acc_in ramps from 0: first WARMUP=3 aligned results dropped; 4th aligned value appears with out_valid at edge k+LAT+1 relative to its in_valid.
- Rounding (ROUND_EN): acc_in=0x017 → out 0x01; 0x018 → 0x02; 0xFF7 → 0xFF, sat_flag stays 0; 0xFF8 → 0xFF, sat_flag=1. Without macro: 0x018 → 0x01, 0xFFF → 0xFF, sat_flag 0.
- Backpressure: out_ready=0, stream 6 post-warm-up samples: level reaches 4, samples 5–6 dropped, drop_flag=1; release out_ready → exactly the first 4 in order.
- Full with simultaneous push/pop: level=4, out_ready=1 and push same cycle → level stays 4, no drop, order preserved.
- Reset mid-stream with level=3 and pulses in flight: after rst, level=0, out_valid=0, flags 0, no stale sample emerges; warm-up restarts.
- Random in_valid/out_ready for 10k cycles against reference model: output sequence matches quantised accepted sums, level never exceeds DEPTH.
